// File: rtl/tx_lane_serializer.sv
// rtl/tx_lane_serializer.sv - serializes an N_LANES-block lane bus into one coded block per i_valid
// Optional sticky overrun/underrun flags are built only when TX_SERIALIZER_STATUS_EN is defined.
module tx_lane_serializer #(
    parameter int NB_DATA_CODED = 66,
    parameter int N_LANES       = 20,
    parameter int NB_LANE_ID    = 5
) (
    input  logic                              i_clock,
    input  logic                              i_reset,
    input  logic                              i_enable,
    input  logic                              i_valid,
    input  logic                              i_load,
    input  logic [NB_DATA_CODED*N_LANES-1:0]  i_data,
    input  logic                              i_clear_status,
    output logic [NB_DATA_CODED-1:0]          o_data,
    output logic                              o_valid,
    output logic [NB_LANE_ID-1:0]             o_lane_id,
    output logic                              o_sof,
    output logic                              o_overrun,
    output logic                              o_underrun
);

    localparam int NB_BUS = NB_DATA_CODED * N_LANES;
    localparam logic [NB_LANE_ID-1:0] LAST_LANE = NB_LANE_ID'(N_LANES - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                    state_q, state_d;
    logic [NB_LANE_ID-1:0]     lane_cnt_q, lane_cnt_d;
    logic [NB_BUS-1:0]         working_q, working_d;
    logic [NB_BUS-1:0]         shadow_q, shadow_d;
    logic                      shadow_full_q, shadow_full_d;
    logic [NB_DATA_CODED-1:0]  data_q, data_d;
    logic                      valid_q, valid_d;
    logic [NB_LANE_ID-1:0]     lane_id_q, lane_id_d;
    logic                      sof_q, sof_d;
    logic [31:0]               lane_ofs;
    logic [NB_BUS-1:0]         work_shift;
    logic                      load_taken;

`ifdef TX_SERIALIZER_STATUS_EN
    logic ovr_evt;
    logic und_evt;
    logic overrun_q, overrun_d;
    logic underrun_q, underrun_d;
`endif

    always_comb begin
        state_d       = state_q;
        lane_cnt_d    = lane_cnt_q;
        working_d     = working_q;
        shadow_d      = shadow_q;
        shadow_full_d = shadow_full_q;
        data_d        = data_q;
        valid_d       = 1'b0;
        lane_id_d     = lane_id_q;
        sof_d         = sof_q;
        load_taken    = 1'b0;
        // Lane 0 sits in the MSBs, so shifting left brings lane_cnt to the top.
        lane_ofs      = 32'(lane_cnt_q) * 32'(NB_DATA_CODED);
        work_shift    = working_q << lane_ofs;
`ifdef TX_SERIALIZER_STATUS_EN
        ovr_evt       = 1'b0;
        und_evt       = 1'b0;
`endif
        if (i_enable) begin
            case (state_q)
                ST_IDLE: begin
                    if (shadow_full_q) begin
                        working_d     = shadow_q;
                        shadow_full_d = 1'b0;
                        lane_cnt_d    = '0;
                        state_d       = ST_RUN;
                    end else if (i_load) begin
                        working_d  = i_data;
                        load_taken = 1'b1;
                        lane_cnt_d = '0;
                        state_d    = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (i_valid) begin
                        valid_d   = 1'b1;
                        data_d    = work_shift[NB_BUS-1 -: NB_DATA_CODED];
                        lane_id_d = lane_cnt_q;
                        sof_d     = (lane_cnt_q == '0);
                        if (lane_cnt_q == LAST_LANE) begin
                            lane_cnt_d = '0;
                            if (shadow_full_q) begin
                                working_d     = shadow_q;
                                shadow_full_d = 1'b0;
                            end else if (i_load) begin
                                working_d  = i_data;
                                load_taken = 1'b1;
                            end else begin
                                state_d = ST_IDLE;
`ifdef TX_SERIALIZER_STATUS_EN
                                und_evt = 1'b1;
`endif
                            end
                        end else begin
                            lane_cnt_d = lane_cnt_q + NB_LANE_ID'(1);
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
            // shadow_full_d is still set only if no transfer drained the shadow this cycle.
            if (i_load && !load_taken) begin
`ifdef TX_SERIALIZER_STATUS_EN
                ovr_evt = shadow_full_d;
`endif
                shadow_d      = i_data;
                shadow_full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q       <= ST_IDLE;
            lane_cnt_q    <= '0;
            working_q     <= '0;
            shadow_q      <= '0;
            shadow_full_q <= 1'b0;
            data_q        <= '0;
            valid_q       <= 1'b0;
            lane_id_q     <= '0;
            sof_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            lane_cnt_q    <= lane_cnt_d;
            working_q     <= working_d;
            shadow_q      <= shadow_d;
            shadow_full_q <= shadow_full_d;
            data_q        <= data_d;
            valid_q       <= valid_d;
            lane_id_q     <= lane_id_d;
            sof_q         <= sof_d;
        end
    end

    assign o_data    = data_q;
    assign o_valid   = valid_q;
    assign o_lane_id = lane_id_q;
    assign o_sof     = sof_q;

`ifdef TX_SERIALIZER_STATUS_EN
    // A new event wins over a same-cycle clear.
    always_comb begin
        overrun_d  = overrun_q;
        underrun_d = underrun_q;
        if (i_enable) begin
            if (ovr_evt) begin
                overrun_d = 1'b1;
            end else if (i_clear_status) begin
                overrun_d = 1'b0;
            end
            if (und_evt) begin
                underrun_d = 1'b1;
            end else if (i_clear_status) begin
                underrun_d = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            overrun_q  <= overrun_d;
            underrun_q <= underrun_d;
        end
    end

    assign o_overrun  = overrun_q;
    assign o_underrun = underrun_q;
`else
    logic status_unused;
    assign status_unused = i_clear_status;
    assign o_overrun     = 1'b0;
    assign o_underrun    = 1'b0;
`endif

endmodule

// File: tb/tb_tx_lane_serializer.sv
// tb/tb_tx_lane_serializer.sv - self-checking bench for tx_lane_serializer against a block-array model
module tb_tx_lane_serializer;

    localparam int NB = 66;
    localparam int NL = 20;
    localparam int NI = 5;

    logic              clk = 1'b0;
    logic              i_reset = 1'b1;
    logic              i_enable = 1'b0;
    logic              i_valid = 1'b0;
    logic              i_load = 1'b0;
    logic [NB*NL-1:0]  i_data = '0;
    logic              i_clear_status = 1'b0;
    logic [NB-1:0]     o_data;
    logic              o_valid;
    logic [NI-1:0]     o_lane_id;
    logic              o_sof;
    logic              o_overrun;
    logic              o_underrun;

    int n_checks = 0;
    int n_fail   = 0;

    logic [NB-1:0] bus_blk  [NL];
    logic [NB-1:0] m_work   [NL];
    logic [NB-1:0] m_shadow [NL];
    bit            m_run, m_sfull, m_ov, m_un;
    int            m_lane;
    logic          e_valid, e_sof, x_ov, x_un;
    logic [NI-1:0] e_lane;
    logic [NB-1:0] e_data;

    tx_lane_serializer #(.NB_DATA_CODED(NB), .N_LANES(NL), .NB_LANE_ID(NI)) dut (
        .i_clock        (clk),
        .i_reset        (i_reset),
        .i_enable       (i_enable),
        .i_valid        (i_valid),
        .i_load         (i_load),
        .i_data         (i_data),
        .i_clear_status (i_clear_status),
        .o_data         (o_data),
        .o_valid        (o_valid),
        .o_lane_id      (o_lane_id),
        .o_sof          (o_sof),
        .o_overrun      (o_overrun),
        .o_underrun     (o_underrun)
    );

    always #5 clk = ~clk;

    task automatic model_update(input logic rst, en, v, ld, clr);
        bit took, xfer, was_full, ov_evt, un_evt;
        took = 0; xfer = 0; ov_evt = 0; un_evt = 0;
        was_full = m_sfull;
        if (rst) begin
            m_run = 0; m_lane = 0; m_sfull = 0; m_ov = 0; m_un = 0;
            for (int k = 0; k < NL; k++) begin
                m_work[k] = '0;
                m_shadow[k] = '0;
            end
            e_valid = 0; e_sof = 0; e_lane = '0; e_data = '0;
        end else begin
            e_valid = 0;
            if (en) begin
                if (!m_run) begin
                    if (m_sfull) begin
                        m_work = m_shadow; m_sfull = 0; xfer = 1; m_lane = 0; m_run = 1;
                    end else if (ld) begin
                        m_work = bus_blk; took = 1; m_lane = 0; m_run = 1;
                    end
                end else if (v) begin
                    e_valid = 1;
                    e_data  = m_work[m_lane];
                    e_lane  = NI'(m_lane);
                    e_sof   = (m_lane == 0);
                    m_lane  = (m_lane + 1) % NL;
                    if (m_lane == 0) begin
                        if (m_sfull) begin
                            m_work = m_shadow; m_sfull = 0; xfer = 1;
                        end else if (ld) begin
                            m_work = bus_blk; took = 1;
                        end else begin
                            m_run = 0; un_evt = 1;
                        end
                    end
                end
                if (ld && !took) begin
                    ov_evt   = was_full && !xfer;
                    m_shadow = bus_blk;
                    m_sfull  = 1;
                end
                if (ov_evt) m_ov = 1; else if (clr) m_ov = 0;
                if (un_evt) m_un = 1; else if (clr) m_un = 0;
            end
        end
`ifdef TX_SERIALIZER_STATUS_EN
        x_ov = m_ov;
        x_un = m_un;
`else
        x_ov = 1'b0;
        x_un = 1'b0;
`endif
    endtask

    task automatic step(input logic rst, en, v, ld, clr);
        i_reset = rst; i_enable = en; i_valid = v; i_load = ld; i_clear_status = clr;
        if (ld) begin
            for (int k = 0; k < NL; k++) i_data[(NL-1-k)*NB +: NB] = bus_blk[k];
        end
        model_update(rst, en, v, ld, clr);
        @(posedge clk);
        #1;
    endtask

    task automatic set_bus(input logic [NB-1:0] base);
        for (int k = 0; k < NL; k++) bus_blk[k] = base + NB'(k);
    endtask

    task automatic set_random_bus();
        for (int k = 0; k < NL; k++) bus_blk[k] = {$urandom, $urandom, $urandom};
    endtask

    task automatic test_reset();
        set_random_bus();
        step(1, 1, 1, 1, 1);
        step(1, 0, 0, 0, 0);
        n_checks++;
        if ({o_valid, o_sof, o_lane_id, o_data, o_overrun, o_underrun} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b sof=%b lane=%0d data=%h ov=%b un=%b, want all 0",
                     o_valid, o_sof, o_lane_id, o_data, o_overrun, o_underrun);
        end
    endtask

    task automatic test_steady_stream();
        step(1, 0, 0, 0, 0);
        set_bus(66'h1);
        step(0, 1, 1, 1, 0);
        for (int c = 1; c < 80; c++) begin
            bit ld;
            ld = (c % 20 == 0);
            if (ld) set_random_bus();
            step(0, 1, 1, ld, 0);
            n_checks++;
            if ({o_valid, o_sof, o_lane_id, o_data} !== {e_valid, e_sof, e_lane, e_data}) begin
                n_fail++;
                $display("FAIL steady c=%0d: got v=%b sof=%b lane=%0d data=%h, want v=%b sof=%b lane=%0d data=%h",
                         c, o_valid, o_sof, o_lane_id, o_data, e_valid, e_sof, e_lane, e_data);
            end
            if (c <= 20) begin
                n_checks++;
                if (o_data !== NB'(c) || o_lane_id !== NI'(c - 1)) begin
                    n_fail++;
                    $display("FAIL steady_first_frame c=%0d: got lane=%0d data=%h, want lane=%0d data=%0d",
                             c, o_lane_id, o_data, c - 1, c);
                end
            end
            n_checks++;
            if ({o_overrun, o_underrun} !== 2'b00) begin
                n_fail++;
                $display("FAIL steady_flags c=%0d: got ov=%b un=%b, want 0 0", c, o_overrun, o_underrun);
            end
        end
    endtask

    task automatic test_underrun();
        int nv;
        nv = 0;
        step(1, 0, 0, 0, 0);
        set_random_bus();
        step(0, 1, 0, 1, 0);
        for (int c = 0; c < 25; c++) begin
            step(0, 1, 1, 0, 0);
            if (o_valid) nv++;
            n_checks++;
            if ({o_valid, o_sof, o_lane_id, o_data} !== {e_valid, e_sof, e_lane, e_data}) begin
                n_fail++;
                $display("FAIL underrun c=%0d: got v=%b lane=%0d data=%h, want v=%b lane=%0d data=%h",
                         c, o_valid, o_lane_id, o_data, e_valid, e_lane, e_data);
            end
        end
        n_checks++;
        if (nv !== 20) begin
            n_fail++;
            $display("FAIL underrun_count: got %0d blocks, want 20", nv);
        end
        n_checks++;
        if (o_underrun !== x_un) begin
            n_fail++;
            $display("FAIL underrun_flag: got %b, want %b", o_underrun, x_un);
        end
        step(0, 1, 0, 0, 1);
        n_checks++;
        if (o_underrun !== 1'b0 || o_underrun !== x_un) begin
            n_fail++;
            $display("FAIL underrun_clear: got %b, want 0", o_underrun);
        end
    endtask

    task automatic test_overrun();
        int nb, nc;
        nb = 0; nc = 0;
        step(1, 0, 0, 0, 0);
        set_bus(66'hA00);
        step(0, 1, 0, 1, 0);
        for (int c = 0; c < 42; c++) begin
            bit ld;
            ld = (c == 3 || c == 8);
            if (c == 3) set_bus(66'hB00);
            if (c == 8) set_bus(66'hC00);
            step(0, 1, 1, ld, 0);
            if (o_valid && o_data[11:8] == 4'hB) nb++;
            if (o_valid && o_data[11:8] == 4'hC) nc++;
            n_checks++;
            if ({o_valid, o_sof, o_lane_id, o_data} !== {e_valid, e_sof, e_lane, e_data}) begin
                n_fail++;
                $display("FAIL overrun c=%0d: got v=%b lane=%0d data=%h, want v=%b lane=%0d data=%h",
                         c, o_valid, o_lane_id, o_data, e_valid, e_lane, e_data);
            end
            n_checks++;
            if (o_overrun !== x_ov) begin
                n_fail++;
                $display("FAIL overrun_flag c=%0d: got %b, want %b", c, o_overrun, x_ov);
            end
        end
        n_checks++;
        if (nb !== 0 || nc !== 20) begin
            n_fail++;
            $display("FAIL overrun_frames: got second-bus=%0d third-bus=%0d blocks, want 0 and 20", nb, nc);
        end
    endtask

    task automatic test_wrap_load();
        step(1, 0, 0, 0, 0);
        set_bus(66'h100);
        step(0, 1, 0, 1, 0);
        for (int c = 0; c < 19; c++) step(0, 1, 1, 0, 0);
        set_bus(66'h200);
        step(0, 1, 1, 1, 0);
        step(0, 1, 1, 0, 0);
        n_checks++;
        if ({o_valid, o_sof, o_lane_id, o_data} !== {1'b1, 1'b1, 5'd0, 66'h200}) begin
            n_fail++;
            $display("FAIL wrap_load: got v=%b sof=%b lane=%0d data=%h, want 1 1 0 200",
                     o_valid, o_sof, o_lane_id, o_data);
        end
        n_checks++;
        if (o_underrun !== 1'b0 || o_overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_load_flags: got ov=%b un=%b, want 0 0", o_overrun, o_underrun);
        end
    endtask

    task automatic test_reset_mid();
        step(1, 0, 0, 0, 0);
        set_bus(66'h300);
        step(0, 1, 0, 1, 0);
        for (int c = 0; c < 7; c++) step(0, 1, 1, 0, 0);
        set_bus(66'h400);
        step(1, 1, 1, 1, 0);
        n_checks++;
        if ({o_valid, o_sof, o_lane_id, o_data, o_overrun, o_underrun} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got v=%b sof=%b lane=%0d data=%h, want all 0",
                     o_valid, o_sof, o_lane_id, o_data);
        end
        step(0, 1, 1, 0, 0);
        n_checks++;
        if (o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_no_data: got v=%b, want 0", o_valid);
        end
        step(0, 1, 0, 1, 0);
        step(0, 1, 1, 0, 0);
        n_checks++;
        if ({o_valid, o_sof, o_lane_id, o_data} !== {1'b1, 1'b1, 5'd0, 66'h400}) begin
            n_fail++;
            $display("FAIL reset_mid_restart: got v=%b sof=%b lane=%0d data=%h, want 1 1 0 400",
                     o_valid, o_sof, o_lane_id, o_data);
        end
    endtask

    task automatic test_enable_low();
        step(1, 0, 0, 0, 0);
        set_bus(66'h500);
        step(0, 1, 0, 1, 0);
        for (int c = 0; c < 6; c++) step(0, 1, 1, 0, 0);
        set_bus(66'h600);
        for (int c = 0; c < 5; c++) begin
            step(0, 0, 1, c[0], 1);
            n_checks++;
            if ({o_valid, o_lane_id, o_data} !== {1'b0, 5'd5, 66'h505}) begin
                n_fail++;
                $display("FAIL enable_low c=%0d: got v=%b lane=%0d data=%h, want 0 5 505",
                         c, o_valid, o_lane_id, o_data);
            end
        end
        for (int c = 0; c < 16; c++) begin
            step(0, 1, 1, 0, 0);
            n_checks++;
            if ({o_valid, o_sof, o_lane_id, o_data} !== {e_valid, e_sof, e_lane, e_data}) begin
                n_fail++;
                $display("FAIL enable_resume c=%0d: got v=%b lane=%0d data=%h, want v=%b lane=%0d data=%h",
                         c, o_valid, o_lane_id, o_data, e_valid, e_lane, e_data);
            end
        end
        n_checks++;
        if (o_underrun !== x_un) begin
            n_fail++;
            $display("FAIL enable_no_capture: got un=%b, want %b", o_underrun, x_un);
        end
    endtask

    task automatic test_random();
        step(1, 0, 0, 0, 0);
        for (int c = 0; c < 600; c++) begin
            bit en, v, ld, clr;
            en  = ($urandom_range(0, 9) != 0);
            v   = ($urandom_range(0, 9) < 8);
            ld  = ($urandom_range(0, 19) == 0);
            clr = ($urandom_range(0, 29) == 0);
            if (ld) set_random_bus();
            step(0, en, v, ld, clr);
            n_checks++;
            if ({o_valid, o_sof, o_lane_id, o_data, o_overrun, o_underrun} !==
                {e_valid, e_sof, e_lane, e_data, x_ov, x_un}) begin
                n_fail++;
                $display("FAIL random c=%0d: got v=%b sof=%b lane=%0d data=%h ov=%b un=%b, want v=%b sof=%b lane=%0d data=%h ov=%b un=%b",
                         c, o_valid, o_sof, o_lane_id, o_data, o_overrun, o_underrun,
                         e_valid, e_sof, e_lane, e_data, x_ov, x_un);
            end
        end
    endtask

    initial begin
        test_reset();
        test_steady_stream();
        test_underrun();
        test_overrun();
        test_wrap_load();
        test_reset_mid();
        test_enable_low();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tx_lane_serializer.md
TX_LANE_SERIALIZER -- requirements
Module: tx_lane_serializer

Interface
REQ-001 SHALL have parameters: NB_DATA_CODED, default 66, coded block width; N_LANES, default 20, number of PCS lanes; NB_LANE_ID, default 5, lane index width.
REQ-002 SHALL have ports (clock and reset first):
- i_clock  in  1  single clock.
- i_reset  in  1  synchronous, active-high reset.
- i_enable  in  1  block enable.
- i_valid  in  1  fast valid, one output block per pulse.
- i_load  in  1  slow valid, N_LANES-block bus present.
- i_data  in  NB_DATA_CODED*N_LANES  lane bus, lane 0 in the MSBs.
- i_clear_status  in  1  clears sticky flags.
- o_data  out  NB_DATA_CODED  serialized block.
- o_valid  out  1  o_data valid.
- o_lane_id  out  NB_LANE_ID  lane of o_data.
- o_sof  out  1  high with lane 0 block.
- o_overrun  out  1  sticky overrun flag.
- o_underrun  out  1  sticky underrun flag.

Function
REQ-003 SHALL hold a working register and a shadow register, each NB_DATA_CODED*N_LANES bits, plus a shadow_full bit.
REQ-004 SHALL capture i_data into shadow and set shadow_full when i_load=1 and i_enable=1.
REQ-005 SHALL use a two-state FSM: IDLE (no working data) and RUN.
REQ-006 IDLE->RUN: when shadow_full=1, or i_load=1 in the same cycle, the data SHALL be moved into working, lane_cnt set to 0 and shadow_full cleared (or left clear).
REQ-007 In RUN with i_valid=1, o_data SHALL be the working lane lane_cnt, registered with one cycle of latency. o_valid=1, o_lane_id=lane_cnt, o_sof=(lane_cnt==0).
REQ-008 lane_cnt SHALL increment per i_valid in RUN and wrap from N_LANES-1 to 0.
REQ-009 At the wrap:
- If shadow_full=1, shadow SHALL move to working, shadow_full SHALL clear and the FSM SHALL stay in RUN.
- Else, if i_load=1 in the same cycle, i_data SHALL load working directly and the FSM SHALL stay in RUN.
- Else, the FSM SHALL go to IDLE and underrun SHALL be flagged.
REQ-010 i_load with shadow_full=1 and no transfer this cycle SHALL overwrite shadow and flag overrun.
REQ-011 If i_load and a shadow-to-working transfer happen in the same cycle, the transfer SHALL use the old shadow, new data SHALL enter shadow, shadow_full SHALL stay 1, and no overrun SHALL be flagged.
REQ-012 o_valid SHALL be 0 in any cycle without an i_valid in RUN. o_data, o_lane_id and o_sof SHALL hold their last values.
REQ-013 With i_enable=0, no capture, advance or transition SHALL occur. o_valid SHALL be 0 and all state SHALL be held.
REQ-014 i_clear_status=1 SHALL clear both sticky flags. A same-cycle set event SHALL take priority.

Reset
REQ-015 On i_reset=1 at a clock edge, the following SHALL take effect on that edge and take priority over all inputs:
- FSM=IDLE, lane_cnt=0, shadow_full=0.
- working and shadow registers =0.
- o_data=0, o_valid=0, o_lane_id=0, o_sof=0, o_overrun=0, o_underrun=0.
REQ-016 Reset mid-frame SHALL discard all buffered data. The first block after reset SHALL come only after a new i_load.

Configuration
REQ-017 Macro TX_SERIALIZER_STATUS_EN defined: o_overrun and o_underrun SHALL be implemented per REQ-009, REQ-010 and REQ-014.
REQ-018 Macro TX_SERIALIZER_STATUS_EN undefined: o_overrun and o_underrun SHALL be tied to 0, and the flag logic SHALL be absent. Data behaviour is unchanged.

Verification
REQ-019 The bench SHALL cover these scenarios (macro defined):
- Steady stream: i_valid every cycle; i_load every 20th cycle, lane k block = 66'h(k+1) -> o_lane_id sequence 0..19 repeating; o_data=k+1; o_sof on lane 0; no flags.
- Underrun: a single i_load, then 25 i_valid -> exactly 20 blocks; FSM IDLE after lane 19; o_underrun=1; o_valid=0 afterwards.
- Overrun: three i_load within one 20-block frame -> o_overrun=1; next frame carries the third bus; the second bus never appears.
- Simultaneous wrap and load with shadow empty: i_load on the lane-19 cycle -> lane 0 of the new bus on the next i_valid; no underrun.
- Reset at lane 7: then i_load -> output restarts at lane 0 of the new bus; all outputs 0 during reset.
- Enable low for 5 cycles mid-frame: lane_cnt frozen; o_valid=0 throughout; resumes at the same lane.
